ex_muldiv_sequencer: RTL and testbench

Multi-cycle RV32M multiply/divide sequencer in the Execute stage, alongside the ALU. It accepts one M-extension operation at a time and runs it as an iterative shift-add multiply or restoring divide. It stalls the pipeline with `busy_o` until the result is ready, then presents the result for one cycle with `done_o`. Its result replaces the ALU result in EX when `done_o` is high.

---
 rtl/ex_muldiv_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 32-cycle shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to use a single-cycle multiplier for all multiply ops.
module ex_muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_q, neg_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode for the accept cycle
    logic            rs1_signed, rs2_signed, sa, sb, neg_in;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        rs1_signed  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
        rs2_signed  = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sa          = rs1_signed & rs1_data_i[XLEN-1];
        sb          = rs2_signed & rs2_data_i[XLEN-1];
        mag_a       = sa ? -rs1_data_i : rs1_data_i;
        mag_b       = sb ? -rs2_data_i : rs2_data_i;
        // Remainder takes the dividend's sign; everything else takes sA^sB
        neg_in      = (funct3_i[2] && funct3_i[1]) ? sa : (sa ^ sb);
        div_by_zero = (rs2_data_i == '0);
        div_ovf     = !funct3_i[0] && (rs1_data_i == MinInt) && (rs2_data_i == '1);
        if (div_by_zero) begin
            special_res = funct3_i[1] ? rs1_data_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : MinInt;
        end
    end

    // One iteration step of each datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_raw, div_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        mul_prod  = neg_q ? -mul_next : mul_next;
        mul_res   = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ok    = ~div_diff[XLEN+1];
        div_next  = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0],
                     acc_q[XLEN-2:0], div_ok};
        div_raw   = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_res   = neg_q ? -div_raw : div_raw;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        fast_prod = neg_in ? -fast_mag : fast_mag;
        fast_res  = (funct3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        f3_d  = funct3_i;
                        neg_d = neg_in;
                        cnt_d = '0;
                        if (funct3_i[2] && (div_by_zero || div_ovf)) begin
                            result_d = special_res;
                            state_d  = StDone;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!funct3_i[2]) begin
                            result_d = fast_res;
                            state_d  = StDone;
                        end
`else
                        else if (!funct3_i[2]) begin
                            acc_d   = {{XLEN{1'b0}}, mag_b};
                            opb_d   = mag_a;
                            state_d = StMul;
                        end
`endif
                        else begin
                            acc_d   = {{XLEN{1'b0}}, mag_a};
                            opb_d   = mag_b;
                            state_d = StDiv;
                        end
                    end
                end
                StMul: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        result_d = mul_res;
                        state_d  = StDone;
                    end
                end
                StDiv: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        result_d = div_res;
                        state_d  = StDone;
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    // A flush landing on DONE kills the instruction, so its pulse is suppressed too
    assign done_o   = (state_q == StDone) && !flush_i && !rst;
    assign busy_o   = !rst && (((state_q == StIdle) && start_i && !flush_i) ||
                               (state_q == StMul) || (state_q == StDiv));
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed self-checking bench for ex_muldiv_sequencer (honours MULDIV_FAST_MUL_EN).
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    // Issue one op starting just after a falling edge; returns cycles until done_o,
    // cycles with busy_o high, the result, and done_o in the following cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cnt,
                         output logic done_next);
        start_i    = 1'b1;
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        lat        = 0;
        busy_cnt   = 0;
        #1;
        while (1) begin
            if (busy_o) busy_cnt++;
            if (done_o || lat >= 100) break;
            @(negedge clk);
            start_i    = 1'b0;
            rs1_data_i = 32'hDEAD_BEEF;
            rs2_data_i = 32'h1234_5678;
            #1;
            lat++;
        end
        res = result_o;
        @(negedge clk);
        #1;
        done_next = done_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b1;
        funct3_i = 3'b100;
        rs1_data_i = 32'd9;
        rs2_data_i = 32'd3;
        flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy_o);
        end
        start_i = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (result_o !== 32'h0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got res=%h done=%b busy=%b want 0/0/0",
                     result_o, done_o, busy_o);
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc; logic dn;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_res: got %h want ffffffeb", r); end
        checks++;
        if (lat !== MulLat) begin errors++; $display("FAIL mul_lat: got %0d want %0d", lat, MulLat); end
        checks++;
        if (bc !== MulLat) begin errors++; $display("FAIL mul_busy: got %0d want %0d", bc, MulLat); end
        checks++;
        if (dn !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b want 0", dn); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; int lat, bc; logic dn;
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, lat, bc, dn);
        checks++;
        if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh: got %h want 40000000", r); end
        do_op(3'b011, 32'h8000_0000, 32'h8000_0000, r, lat, bc, dn);
        checks++;
        if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulhu: got %h want 40000000", r); end
        do_op(3'b010, 32'hFFFF_FFFF, 32'd2, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu: got %h want ffffffff", r); end
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max: got %h want fffffffe", r); end
        do_op(3'b001, 32'hFFFF_FFFF, 32'd1, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_neg: got %h want ffffffff", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat, bc; logic dn;
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div: got %h want fffffffd", r); end
        checks++;
        if (lat !== DivLat || bc !== DivLat) begin
            errors++; $display("FAIL div_lat: got lat=%0d busy=%0d want %0d", lat, bc, DivLat);
        end
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem: got %h want ffffffff", r); end
        do_op(3'b101, 32'd100, 32'd7, r, lat, bc, dn);
        checks++;
        if (r !== 32'd14) begin errors++; $display("FAIL divu: got %h want 0000000e", r); end
        do_op(3'b111, 32'd100, 32'd7, r, lat, bc, dn);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL remu: got %h want 00000002", r); end
        do_op(3'b101, 32'hFFFF_FFFF, 32'd1, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max: got %h want ffffffff", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat, bc; logic dn;
        do_op(3'b101, 32'd5, 32'd0, r, lat, bc, dn);
        checks++;
        if (r !== 32'hFFFF_FFFF || lat !== 1 || bc !== 1) begin
            errors++; $display("FAIL divu_zero: got res=%h lat=%0d busy=%0d want ffffffff/1/1", r, lat, bc);
        end
        do_op(3'b110, 32'd5, 32'd0, r, lat, bc, dn);
        checks++;
        if (r !== 32'd5 || lat !== 1) begin
            errors++; $display("FAIL rem_zero: got res=%h lat=%0d want 00000005/1", r, lat);
        end
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, dn);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 1) begin
            errors++; $display("FAIL div_ovf: got res=%h lat=%0d want 80000000/1", r, lat);
        end
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, dn);
        checks++;
        if (r !== 32'h0 || lat !== 1 || dn !== 1'b0) begin
            errors++; $display("FAIL rem_ovf: got res=%h lat=%0d next_done=%b want 0/1/0", r, lat, dn);
        end
    endtask

    // Second op issued in the IDLE cycle right after the previous DONE
    task automatic test_back_to_back();
        logic [31:0] r; int lat, bc; logic dn;
        do_op(3'b111, 32'd23, 32'd5, r, lat, bc, dn);
        checks++;
        if (r !== 32'd3) begin errors++; $display("FAIL b2b_first: got %h want 00000003", r); end
        do_op(3'b101, 32'd23, 32'd5, r, lat, bc, dn);
        checks++;
        if (r !== 32'd4 || lat !== DivLat) begin
            errors++; $display("FAIL b2b_second: got res=%h lat=%0d want 00000004/%0d", r, lat, DivLat);
        end
    endtask

    // Result of the last completed op is 32'd4 from test_back_to_back
    task automatic test_flush();
        logic [31:0] r; int lat, bc; logic dn;
        start_i = 1'b1; funct3_i = 3'b101; rs1_data_i = 32'd100; rs2_data_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd4) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b done=%b res=%h want 0/0/00000004",
                     busy_o, done_o, result_o);
        end
        do_op(3'b000, 32'd3, 32'd4, r, lat, bc, dn);
        checks++;
        if (r !== 32'd12 || lat !== MulLat) begin
            errors++; $display("FAIL flush_then_mul: got res=%h lat=%0d want 0000000c/%0d", r, lat, MulLat);
        end
    endtask

    task automatic test_rst_mid();
        int seen = 0;
        start_i = 1'b1; funct3_i = 3'b100; rs1_data_i = 32'hFFFF_FFF9; rs2_data_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (result_o !== 32'h0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got res=%h done=%b busy=%b want 0/0/0", result_o, done_o, busy_o);
        end
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done_o) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
